// File: rtl/axis_byte_serializer.sv
// axis_byte_serializer
// Takes dense N-byte AXI-Stream words and emits them one byte per clock,
// most significant byte first, with out_tlast on the final byte of a word.
// A new word is accepted in the same cycle that the last byte of the
// current word leaves, so the output runs at one byte per cycle with no
// bubble between words.
//
// Optional build macro: AXIS_BYTE_SERIALIZER_STATS_EN
//   When defined, byte_count / word_count output ports are added. They count
//   output transfers and output transfers carrying out_tlast, and wrap modulo
//   2^32.

module axis_byte_serializer #(
    parameter int N = 10
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [8*N-1:0] in_tdata,
    input  logic           in_tvalid,
    output logic           in_tready,
    output logic [7:0]     out_tdata,
    output logic           out_tvalid,
    input  logic           out_tready,
`ifdef AXIS_BYTE_SERIALIZER_STATS_EN
    output logic           out_tlast,
    output logic [31:0]    byte_count,
    output logic [31:0]    word_count
`else
    output logic           out_tlast
`endif
);

    // Byte index width; a one-byte word still gets a 1-bit counter.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = 8 * N;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    // Registered state
    logic [WW-1:0] word_r;
    logic [CW-1:0] cnt_r;
    logic          valid_r;
    logic          last_r;

    // Next-state values
    logic [WW-1:0] word_nxt_s;
    logic [CW-1:0] cnt_nxt_s;
    logic          valid_nxt_s;
    logic          last_nxt_s;

    // Handshake qualifiers
    logic          ready_s;
    logic          in_xfer_s;
    logic          out_xfer_s;

    // Accept a word when the output is empty or its final byte is leaving.
    always_comb begin
        ready_s    = aresetn & (~valid_r | (out_tready & last_r));
        in_xfer_s  = in_tvalid & ready_s;
        out_xfer_s = valid_r & out_tready;
    end

    // Next-state selection for word register, byte index and valid flag.
    always_comb begin
        word_nxt_s  = word_r;
        cnt_nxt_s   = cnt_r;
        valid_nxt_s = valid_r;
        if (!valid_r) begin
            // Idle: load a word if one is offered.
            if (in_xfer_s) begin
                word_nxt_s  = in_tdata;
                cnt_nxt_s   = {CW{1'b0}};
                valid_nxt_s = 1'b1;
            end else begin
                word_nxt_s  = word_r;
                cnt_nxt_s   = cnt_r;
                valid_nxt_s = 1'b0;
            end
        end else if (out_xfer_s) begin
            if (cnt_r != LAST_IDX) begin
                // Mid-word: expose the next byte at the top of the register.
                word_nxt_s  = word_r << 8;
                cnt_nxt_s   = cnt_r + CW'(1);
                valid_nxt_s = 1'b1;
            end else if (in_xfer_s) begin
                // Last byte leaves while the next word arrives: no bubble.
                word_nxt_s  = in_tdata;
                cnt_nxt_s   = {CW{1'b0}};
                valid_nxt_s = 1'b1;
            end else begin
                // Last byte leaves with nothing pending: go idle.
                word_nxt_s  = word_r;
                cnt_nxt_s   = {CW{1'b0}};
                valid_nxt_s = 1'b0;
            end
        end else begin
            // Stall: everything presented downstream must hold still.
            word_nxt_s  = word_r;
            cnt_nxt_s   = cnt_r;
            valid_nxt_s = valid_r;
        end
        last_nxt_s = valid_nxt_s & (cnt_nxt_s == LAST_IDX);
    end

    // State registers with synchronous active-low reset; a reset mid-word
    // drops the remaining bytes so the next word starts at byte 0.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            word_r  <= {WW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            word_r  <= word_nxt_s;
            cnt_r   <= cnt_nxt_s;
            valid_r <= valid_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Outputs come straight from registers; in_tready is a function of
    // registered state plus out_tready and never looks at in_tvalid.
    always_comb begin
        in_tready  = ready_s;
        out_tdata  = word_r[WW-1 -: 8];
        out_tvalid = valid_r;
        out_tlast  = last_r;
    end

`ifdef AXIS_BYTE_SERIALIZER_STATS_EN
    logic [31:0] byte_count_r;
    logic [31:0] word_count_r;

    // Transfer statistics; both counters wrap naturally at 2^32.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            byte_count_r <= 32'd0;
            word_count_r <= 32'd0;
        end else begin
            if (out_xfer_s) begin
                byte_count_r <= byte_count_r + 32'd1;
            end else begin
                byte_count_r <= byte_count_r;
            end
            if (out_xfer_s && last_r) begin
                word_count_r <= word_count_r + 32'd1;
            end else begin
                word_count_r <= word_count_r;
            end
        end
    end

    // Expose statistics registers.
    always_comb begin
        byte_count = byte_count_r;
        word_count = word_count_r;
    end
`endif

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Testbench for axis_byte_serializer (N = 10).
// Scoreboard: every accepted input word pushes its N bytes (with the expected
// last flag) into a queue; every output transfer pops and compares.
// Directed sequences additionally check timing, stalls and reset behaviour.

module tb_axis_byte_serializer;

    localparam int N = 10;

    logic           aclk;
    logic           aresetn;
    logic [8*N-1:0] in_tdata;
    logic           in_tvalid;
    logic           in_tready;
    logic [7:0]     out_tdata;
    logic           out_tvalid;
    logic           out_tready;
    logic           out_tlast;
`ifdef AXIS_BYTE_SERIALIZER_STATS_EN
    logic [31:0]    byte_count;
    logic [31:0]    word_count;
`endif

    axis_byte_serializer #(.N(N)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
`ifdef AXIS_BYTE_SERIALIZER_STATS_EN
        .out_tlast  (out_tlast),
        .byte_count (byte_count),
        .word_count (word_count)
`else
        .out_tlast  (out_tlast)
`endif
    );

    // Clock generation
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bytes  = 0;
    int n_words  = 0;

    logic [8:0] sb_q[$];

    logic [8*N-1:0] w1;
    logic [8*N-1:0] w2;
    logic [8*N-1:0] w3;
    logic [8*N-1:0] w4;
    logic [2*8*N-1:0] w12;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            sb_q.delete();
        end else begin
            if (out_tvalid && out_tready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_byte", 32'(out_tdata), 32'hFFFF);
                end else begin
                    logic [8:0] e;
                    e = sb_q.pop_front();
                    check("sb_data", 32'(out_tdata), 32'(e[7:0]));
                    check("sb_last", 32'(out_tlast), 32'(e[8]));
                end
                n_bytes++;
                if (out_tlast) n_words++;
            end
            if (in_tvalid && in_tready) begin
                for (int k = 0; k < N; k++) begin
                    sb_q.push_back({(k == N - 1), in_tdata[8*(N-k)-1 -: 8]});
                end
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Offer a word and wait (bounded) until it is accepted.
    task automatic send_word(input logic [8*N-1:0] w, input bit hold);
        bit acc;
        int t;
        in_tdata  = w;
        in_tvalid = 1'b1;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 200) begin
            @(negedge aclk);
            acc = in_tready;
            step();
            t++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        if (!hold) in_tvalid = 1'b0;
    endtask

    // Let the output drain for a bounded number of cycles.
    task automatic drain(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        logic [31:0] snap_b;
        logic [31:0] snap_w;
        w1 = "ABCDEFGHIJ";
        w2 = "KLMNOPQRST";
        w3 = "HELLOWORLD";
        w4 = "SHUDESHUDE";
        w12 = {w1, w2};

        aresetn    = 1'b0;
        in_tvalid  = 1'b0;
        in_tdata   = '0;
        out_tready = 1'b1;
        step();
        step();
        @(negedge aclk);
        check("rst_tvalid", 32'(out_tvalid), 32'd0);
        check("rst_tlast",  32'(out_tlast),  32'd0);
        check("rst_tdata",  32'(out_tdata),  32'd0);
        check("rst_tready", 32'(in_tready),  32'd0);
        step();
        aresetn = 1'b1;
        step();

        // Single word with detailed timing
        in_tdata  = w1;
        in_tvalid = 1'b1;
        @(negedge aclk);
        check("idle_tready", 32'(in_tready), 32'd1);
        step();
        in_tvalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge aclk);
            check("t1_valid", 32'(out_tvalid), 32'd1);
            check("t1_data",  32'(out_tdata),  32'(w1[8*N-1-8*i -: 8]));
            check("t1_last",  32'(out_tlast),  32'(i == N - 1));
            check("t1_ready", 32'(in_tready),  32'(i == N - 1));
            step();
        end
        @(negedge aclk);
        check("t1_idle", 32'(out_tvalid), 32'd0);
        step();

        // Back-to-back words: 20 consecutive valid bytes
`ifdef AXIS_BYTE_SERIALIZER_STATS_EN
        snap_b = byte_count;
        snap_w = word_count;
`endif
        in_tdata  = w1;
        in_tvalid = 1'b1;
        step();
        in_tdata = w2;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge aclk);
            check("b2b_valid", 32'(out_tvalid), 32'd1);
            check("b2b_data",  32'(out_tdata),  32'(w12[16*N-1-8*i -: 8]));
            check("b2b_last",  32'(out_tlast),  32'(i == N - 1 || i == 2 * N - 1));
            if (i == N - 1) check("b2b_ready_j", 32'(in_tready), 32'd1);
            step();
            if (i == N - 1) in_tvalid = 1'b0;
        end
        @(negedge aclk);
        check("b2b_idle", 32'(out_tvalid), 32'd0);
`ifdef AXIS_BYTE_SERIALIZER_STATS_EN
        check("stat_bytes", byte_count - snap_b, 32'd20);
        check("stat_words", word_count - snap_w, 32'd2);
`endif
        step();

        // Gaps in valid: word, idle, word; then a word pending before 'J'
        send_word(w1, 1'b0);
        drain(N + 2);
        @(negedge aclk);
        check("gap_idle", 32'(out_tvalid), 32'd0);
        step();
        send_word(w3, 1'b0);
        drain(3);
        send_word(w1, 1'b0);
        @(negedge aclk);
        check("gap_nobubble_first", 32'(out_tdata), 32'(w1[8*N-1 -: 8]));
        check("gap_nobubble_valid", 32'(out_tvalid), 32'd1);
        drain(N + 2);

        // Backpressure while 'D' is presented
        send_word(w1, 1'b0);
        step();
        step();
        step();
        out_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bp_data",  32'(out_tdata),  32'(8'h44));
            check("bp_valid", 32'(out_tvalid), 32'd1);
            check("bp_cnt",   32'(dut.cnt_r),  32'd3);
            step();
        end
        out_tready = 1'b1;
        @(negedge aclk);
        check("bp_release", 32'(out_tdata), 32'(8'h44));
        step();
        @(negedge aclk);
        check("bp_next", 32'(out_tdata), 32'(8'h45));
        drain(5);
        // Now 'J' presented; stall it with a word waiting
        out_tready = 1'b0;
        in_tdata   = w2;
        in_tvalid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge aclk);
            check("bpj_data",  32'(out_tdata), 32'(8'h4A));
            check("bpj_last",  32'(out_tlast), 32'd1);
            check("bpj_ready", 32'(in_tready), 32'd0);
            step();
        end
        out_tready = 1'b1;
        @(negedge aclk);
        check("bpj_ready_rel", 32'(in_tready), 32'd1);
        step();
        in_tvalid = 1'b0;
        @(negedge aclk);
        check("bpj_next", 32'(out_tdata), 32'(8'h4B));
        drain(N + 2);

        // Reset mid-word after 'C' has been sent
        send_word(w1, 1'b0);
        step();
        step();
        step();
        aresetn = 1'b0;
        @(negedge aclk);
        check("mrst_ready_now", 32'(in_tready), 32'd0);
        step();
        @(negedge aclk);
        check("mrst_valid", 32'(out_tvalid), 32'd0);
        check("mrst_last",  32'(out_tlast),  32'd0);
        check("mrst_data",  32'(out_tdata),  32'd0);
        check("mrst_ready", 32'(in_tready),  32'd0);
        step();
        aresetn = 1'b1;
        send_word(w4, 1'b0);
        @(negedge aclk);
        check("mrst_first", 32'(out_tdata), 32'(8'h53));
        drain(N + 2);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef AXIS_BYTE_SERIALIZER_STATS_EN
        // Wrap-around: preload just below 2^32, then send one word
        force dut.byte_count_r = 32'hFFFFFFFE;
        step();
        release dut.byte_count_r;
        send_word(w3, 1'b0);
        drain(N + 2);
        @(negedge aclk);
        check("stat_wrap", byte_count, 32'd8);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_byte_serializer.md
Name: axis_byte_serializer

Overview:
- Downstream neighbour of the `packing` stage. Consumes its dense N-byte AXI-Stream words; every byte of every word is valid.
- Emits the word one byte per clock on an 8-bit AXI-Stream, most significant byte first. A word carrying "ABCDEFGHIJ" leaves as 'A','B',…,'J'.
- Sustains one byte per cycle across word boundaries with no bubble. Marks the last byte of each word with out_tlast.

Parameters:
- N, 10, bytes per input word. Legal range N >= 1.

Ports:
- aclk  input  1  clock; all state updates on its rising edge
- aresetn  input  1  synchronous, active-low reset, sampled on rising edge of aclk
- in_tdata  input  8*N  packed input word; byte k = in_tdata[8*(N-k)-1 -: 8], k=0 is sent first
- in_tvalid  input  1  input word valid
- in_tready  output  1  serializer can accept a word this cycle
- out_tdata  output  8  current output byte
- out_tvalid  output  1  output byte valid
- out_tready  input  1  downstream accepts byte
- out_tlast  output  1  high with the final byte (k=N-1) of each word

Behaviour:
- State:
  - word register: 8*N bits.
  - byte index cnt: width max(1, $clog2(N)), range 0..N-1.
  - valid flag: drives out_tvalid.
- Reset (aresetn=0 at a rising edge):
  - out_tvalid=0, out_tlast=0, out_tdata=8'h00, cnt=0, word register cleared.
  - in_tready is forced 0 while aresetn=0.
  - Reset mid-word discards the remaining bytes. The next accepted word starts at k=0.
- Handshakes:
  - Input transfer: in_tvalid & in_tready at a rising edge.
  - Output transfer: out_tvalid & out_tready at a rising edge.
- in_tready is combinational from registered state:
  - in_tready = aresetn & (!out_tvalid | (out_tready & out_tlast)).
  - It never depends on in_tvalid.
- out_tdata = word register [8N-1:8N-8].
- out_tlast = out_tvalid & (cnt==N-1).
- Latency: byte 0 of an accepted word is presented on out_tdata/out_tvalid the cycle after the input transfer.
- Per rising edge (aresetn=1):
  - Idle (!out_tvalid) and input transfer: load word register, cnt=0, out_tvalid=1.
  - Output transfer with cnt<N-1: shift word register left by 8, cnt=cnt+1.
  - Output transfer with cnt==N-1 and simultaneous input transfer: load the new word, cnt=0, out_tvalid stays 1. This is back-to-back with no bubble.
  - Output transfer with cnt==N-1 and no input transfer: out_tvalid=0, cnt=0.
  - Stall (out_tvalid & !out_tready): out_tdata, out_tlast and cnt hold unchanged. AXI stability rule.
- Input data arriving while in_tready=0 is ignored and stays with the producer.
- N=1: every byte is last, and in_tready = aresetn & (!out_tvalid | out_tready).
- Sustained throughput: 1 byte/cycle when in_tvalid and out_tready are held high. Input acceptance rate is 1 word per N cycles.

Optional Feature:
- Macro: AXIS_BYTE_SERIALIZER_STATS_EN.
- When defined, two extra output ports are added:
  - byte_count [31:0]: increments on every output transfer.
  - word_count [31:0]: increments on every output transfer with out_tlast=1.
  - Both reset to 0 and wrap modulo 2^32 (0xFFFFFFFF+1 -> 0).
- When not defined, these ports and their logic do not exist. All other behaviour is identical either way.

Test Plan:
- Single word: N=10, out_tready=1, one transfer of "ABCDEFGHIJ".
  - out_tdata = 'A'..'J' on 10 consecutive cycles starting one cycle after the transfer.
  - out_tlast=1 only with 'J'; in_tready=0 from 'A' through 'I', 1 during 'J'; then out_tvalid=0.
- Back-to-back: in_tvalid held 1 with "ABCDEFGHIJ" then "KLMNOPQRST".
  - 20 consecutive valid bytes 'A'..'T', no bubble between 'J' and 'K'.
  - out_tlast on 'J' and 'T'.
- Gaps in valid: words alternate with idle in_tvalid cycles ("ABCDEFGHIJ", gap, "HELLOWORLD").
  - Byte streams intact and in order; out_tvalid drops only when no word is pending after 'J'.
- Backpressure: out_tready=0 for 3 cycles while 'D' is presented.
  - out_tdata='D', out_tvalid=1, cnt unchanged for all 3 cycles; 'E' follows after release.
  - Backpressure during 'J' with in_tvalid=1 keeps in_tready=0 and the next word unconsumed.
- Reset mid-word: aresetn=0 for 2 cycles after 'C' is sent.
  - out_tvalid=0, out_tlast=0, out_tdata=0 and in_tready=0 during reset.
  - The next word "SHUDESHUDE" emits starting at 'S'.
- With AXIS_BYTE_SERIALIZER_STATS_EN defined, after the back-to-back test: byte_count=20, word_count=2.
  - Preloading near 0xFFFFFFFF (via long run or force) shows wrap to 0.
